// File: rtl/binarydivision_hls_dbg_pkg.sv
// -----------------------------------------------------------------------------
// binarydivision_hls_dbg_pkg
// Shared definitions for the binaryDivision HLS debug/deadlock-report logic:
//   - dbg_state_e : report controller state encoding
//   - DEF_THRESH  : default persistence threshold in cycles
//   - clog2       : ceiling log2 helper usable in parameter expressions
// -----------------------------------------------------------------------------
package binarydivision_hls_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WATCH    = 2'd1,
    REPORT   = 2'd2,
    COOLDOWN = 2'd3
  } dbg_state_e;

  localparam int unsigned DEF_THRESH = 32'd1024;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = $unsigned(i + 1);
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/binarydivision_hls_lsb_encoder.sv
// -----------------------------------------------------------------------------
// binarydivision_hls_lsb_encoder
// Purely combinational lowest-set-bit priority encoder.
// Ports:
//   vec   in  NUM_MON  input bit vector
//   idx   out IDX_W    index of the lowest set bit (0 when vec is all zero),
//                      truncated/extended to IDX_W
//   valid out 1        vec has at least one bit set
// -----------------------------------------------------------------------------
module binarydivision_hls_lsb_encoder
  import binarydivision_hls_dbg_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_MON-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Internal scan width covers every index even if IDX_W was chosen narrower.
  localparam int SCAN_W = (clog2(NUM_MON) < 32'd1) ? 1 : int'(clog2(NUM_MON));

  logic [SCAN_W-1:0] scan_idx_s;

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    scan_idx_s = {SCAN_W{1'b0}};
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      scan_idx_s = vec[i] ? SCAN_W'(i) : scan_idx_s;
    end
  end

  assign idx   = IDX_W'(scan_idx_s);
  assign valid = |vec;

endmodule

// File: rtl/binarydivision_hls_deadlock_report_ctrl.sv
// -----------------------------------------------------------------------------
// binarydivision_hls_deadlock_report_ctrl
// Qualifies the per-instance deadlock monitor block flags of the binaryDivision
// HLS design. A report is raised only when the same non-empty set of blocked
// monitors persists for T_eff cycles (threshold, with 0 treated as 1). The
// report is sticky until acknowledged; afterwards the controller stays quiet
// until every block flag has cleared, so a single hang yields a single report.
// Ports:
//   clock        in  1        rising-edge clock
//   reset        in  1        synchronous active-high reset
//   enable       in  1        detection enable
//   threshold    in  CNT_W    required persistence in cycles (0 acts as 1)
//   mon_block    in  NUM_MON  block flags, one per monitor
//   ack          in  1        acknowledge of the active report
//   deadlock     out 1        report active
//   deadlock_idx out IDX_W    lowest blocked monitor in the captured snapshot
//   deadlock_vec out NUM_MON  captured snapshot of mon_block
//   persist_cnt  out CNT_W    current persistence count
//   evt_cnt      out EVT_W    saturating count of reports since reset
//   busy         out 1        controller not idle
// All outputs are registered.
// -----------------------------------------------------------------------------
module binarydivision_hls_deadlock_report_ctrl
  import binarydivision_hls_dbg_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 2,
  parameter int EVT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [CNT_W-1:0]   threshold,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               ack,
  output logic               deadlock,
  output logic [IDX_W-1:0]   deadlock_idx,
  output logic [NUM_MON-1:0] deadlock_vec,
  output logic [CNT_W-1:0]   persist_cnt,
  output logic [EVT_W-1:0]   evt_cnt,
  output logic               busy
);

  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [EVT_W-1:0]   EVT_ONE  = EVT_W'(1);
  localparam logic [EVT_W-1:0]   EVT_MAX  = {EVT_W{1'b1}};
  localparam logic [NUM_MON-1:0] MON_ZERO = {NUM_MON{1'b0}};
  localparam logic [IDX_W-1:0]   IDX_ZERO = {IDX_W{1'b0}};

  dbg_state_e         state_r;
  dbg_state_e         state_nxt_s;
  logic [NUM_MON-1:0] snap_r;
  logic [NUM_MON-1:0] snap_nxt_s;
  logic [CNT_W-1:0]   persist_r;
  logic [CNT_W-1:0]   persist_nxt_s;
  logic [CNT_W-1:0]   persist_inc_s;
  logic [CNT_W-1:0]   t_eff_s;
  logic               report_entry_s;
  logic               report_exit_s;
  logic [IDX_W-1:0]   enc_idx_s;
  logic               enc_valid_s;

  logic               deadlock_r;
  logic [IDX_W-1:0]   idx_r;
  logic [NUM_MON-1:0] vec_r;
  logic [EVT_W-1:0]   evt_r;
  logic               busy_r;

  assign t_eff_s       = (threshold == CNT_ZERO) ? CNT_ONE : threshold;
  assign persist_inc_s = (persist_r == CNT_MAX) ? persist_r : (persist_r + CNT_ONE);

  // The encoder looks at the snapshot that will be live after this edge, so a
  // report entered straight from IDLE reports the freshly captured flags.
  binarydivision_hls_lsb_encoder #(
    .NUM_MON (NUM_MON),
    .IDX_W   (IDX_W)
  ) u_lsb_encoder (
    .vec   (snap_nxt_s),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  // Next-state, snapshot and persistence-count decisions.
  always_comb begin
    state_nxt_s    = state_r;
    snap_nxt_s     = snap_r;
    persist_nxt_s  = persist_r;
    report_entry_s = 1'b0;
    report_exit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && (mon_block != MON_ZERO)) begin
          snap_nxt_s    = mon_block;
          persist_nxt_s = CNT_ONE;
          if (t_eff_s == CNT_ONE) begin
            state_nxt_s    = REPORT;
            report_entry_s = 1'b1;
          end else begin
            state_nxt_s = WATCH;
          end
        end else begin
          persist_nxt_s = CNT_ZERO;
        end
      end
      WATCH: begin
        // Losing enable (or all blocks clearing) wins over reaching threshold.
        if (!enable || (mon_block == MON_ZERO)) begin
          state_nxt_s   = IDLE;
          persist_nxt_s = CNT_ZERO;
        end else if (mon_block != snap_r) begin
          snap_nxt_s    = mon_block;
          persist_nxt_s = CNT_ONE;
        end else begin
          persist_nxt_s = persist_inc_s;
          if (persist_inc_s >= t_eff_s) begin
            state_nxt_s    = REPORT;
            report_entry_s = 1'b1;
          end else begin
            state_nxt_s = WATCH;
          end
        end
      end
      REPORT: begin
        if (ack) begin
          state_nxt_s   = COOLDOWN;
          report_exit_s = 1'b1;
        end else begin
          state_nxt_s = REPORT;
        end
      end
      COOLDOWN: begin
        if (mon_block == MON_ZERO) begin
          state_nxt_s   = IDLE;
          persist_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s = COOLDOWN;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        persist_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // State, snapshot, persistence counter and busy flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      snap_r    <= MON_ZERO;
      persist_r <= CNT_ZERO;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      snap_r    <= snap_nxt_s;
      persist_r <= persist_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  // Report registers: set on entry, deadlock cleared on ack, vec/idx retained.
  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock_r <= 1'b0;
      idx_r      <= IDX_ZERO;
      vec_r      <= MON_ZERO;
      evt_r      <= {EVT_W{1'b0}};
    end else if (report_entry_s) begin
      deadlock_r <= 1'b1;
      vec_r      <= snap_nxt_s;
      idx_r      <= enc_valid_s ? enc_idx_s : IDX_ZERO;
      evt_r      <= (evt_r == EVT_MAX) ? evt_r : (evt_r + EVT_ONE);
    end else if (report_exit_s) begin
      deadlock_r <= 1'b0;
    end else begin
      deadlock_r <= deadlock_r;
    end
  end

  assign deadlock     = deadlock_r;
  assign deadlock_idx = idx_r;
  assign deadlock_vec = vec_r;
  assign persist_cnt  = persist_r;
  assign evt_cnt      = evt_r;
  assign busy         = busy_r;

endmodule
